// File: rtl/scroll_pkg.sv
// rtl/scroll_pkg.sv - shared types, constants and rotation helper for word_scroll_ctrl
package scroll_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int NUM_CHARS = 3;
  localparam int CHAR_W    = 2;

  // Mod-3 rotation step; rev selects 0->2->1->0 instead of 0->1->2->0.
  function automatic logic [1:0] rot_advance(input logic [1:0] rot, input logic rev);
    logic [1:0] nxt;
    case (rot)
      2'd0:    nxt = rev ? 2'd2 : 2'd1;
      2'd1:    nxt = rev ? 2'd0 : 2'd2;
      2'd2:    nxt = rev ? 2'd1 : 2'd0;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/word_scroll_ctrl_rate_divider.sv
// rtl/word_scroll_ctrl_rate_divider.sv - prescaler counting 0..TICK_DIV-1 with terminal-count strobe
module rate_divider #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  input  logic clear,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;

  // tc is combinational so the owner can act on the same edge that wraps the count.
  assign tc = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/word_scroll_ctrl.sv
// rtl/word_scroll_ctrl.sv - timed three-character word rotator; `SCROLL_DIR_EN enables the dir input
module word_scroll_ctrl
  import scroll_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [5:0] word_in,
  input  logic       load,
  input  logic       run,
  input  logic       dir,
  output logic [1:0] char0,
  output logic [1:0] char1,
  output logic [1:0] char2,
  output logic [1:0] rot_sel,
  output logic       tick,
  output logic       load_ack,
  output logic       running
);

  state_t     state_q, state_d;
  logic [5:0] word_q, word_d;
  logic [1:0] rot_d;
  logic       cnt_en, advance, tc, rev;

`ifdef SCROLL_DIR_EN
  assign rev = dir;
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign rev        = 1'b0;
`endif

  rate_divider #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_div (
    .clk    (CLOCK_50),
    .resetn (resetn),
    .enable (cnt_en),
    .clear  (load),
    .tc     (tc)
  );

  function automatic logic [CHAR_W-1:0] pick(input logic [5:0] w, input logic [1:0] r, input int k);
    int s;
    s = k + int'(r);
    if (s >= NUM_CHARS) s = s - NUM_CHARS;
    return w[CHAR_W*s +: CHAR_W];
  endfunction

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Load overrides everything, including a terminal count in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_en  = 1'b0;
    advance = 1'b0;
    if (load) begin
      state_d = run ? RUN : PAUSE;
    end else begin
      case (state_q)
        IDLE:  state_d = IDLE;
        RUN: begin
          if (!run) begin
            state_d = PAUSE;
          end else begin
            cnt_en  = 1'b1;
            advance = tc;
          end
        end
        PAUSE: if (run) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    word_d = load ? word_in : word_q;
    rot_d  = rot_sel;
    if (load)         rot_d = 2'd0;
    else if (advance) rot_d = rot_advance(rot_sel, rev);
  end

  // Chars are registered from the next word/rotation so they change with rot_sel.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      word_q   <= '0;
      rot_sel  <= 2'd0;
      char0    <= '0;
      char1    <= '0;
      char2    <= '0;
      tick     <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      word_q   <= word_d;
      rot_sel  <= rot_d;
      char0    <= pick(word_d, rot_d, 0);
      char1    <= pick(word_d, rot_d, 1);
      char2    <= pick(word_d, rot_d, 2);
      tick     <= advance;
      load_ack <= load;
    end
  end

  assign running = (state_q == RUN);

endmodule

// File: tb/tb_word_scroll_ctrl.sv
// tb/tb_word_scroll_ctrl.sv - scoreboard bench for word_scroll_ctrl with TICK_DIV=4
module tb_word_scroll_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       resetn, load, run, dir;
  logic [5:0] word_in;
  logic [1:0] char0, char1, char2, rot_sel;
  logic       tick, load_ack, running;

  int checks   = 0;
  int failures = 0;

  logic [10:0] sb[$];

  int         ms, mcnt, mrot;
  logic [5:0] mword;
  logic       mtick, mack;

  word_scroll_ctrl #(.TICK_DIV(TD), .CNT_W(3)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .word_in  (word_in),
    .load     (load),
    .run      (run),
    .dir      (dir),
    .char0    (char0),
    .char1    (char1),
    .char2    (char2),
    .rot_sel  (rot_sel),
    .tick     (tick),
    .load_ack (load_ack),
    .running  (running)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] mchar(input int k);
    int s;
    s = (k + mrot) % 3;
    return mword[2*s +: 2];
  endfunction

  function automatic int madv(input int r, input logic d);
`ifdef SCROLL_DIR_EN
    if (d) return (r + 2) % 3;
`endif
    return (r + 1) % 3;
  endfunction

  task automatic model_step();
    mtick = 1'b0;
    mack  = 1'b0;
    if (!resetn) begin
      ms = 0; mcnt = 0; mrot = 0; mword = '0;
    end else if (load) begin
      mword = word_in; mrot = 0; mcnt = 0; mack = 1'b1;
      ms = run ? 1 : 2;
    end else if (ms == 1) begin
      if (!run) ms = 2;
      else if (mcnt == TD - 1) begin
        mcnt = 0; mrot = madv(mrot, dir); mtick = 1'b1;
      end else mcnt++;
    end else if (ms == 2) begin
      if (run) ms = 1;
    end
    sb.push_back({mchar(2), mchar(1), mchar(0), 2'(mrot), mtick, mack, ms == 1});
  endtask

  task automatic cycle();
    logic [10:0] exp;
    model_step();
    @(posedge clk);
    @(negedge clk);
    exp = sb.pop_front();
    check("sb", {char2, char1, char0, rot_sel, tick, load_ack, running}, exp);
  endtask

  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_load();
    load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  int n, ticks;
  logic [1:0] seq [3];

  initial begin
    resetn = 1'b0; load = 1'b0; run = 1'b0; dir = 1'b0; word_in = 6'b10_01_00;
    cycle();
    resetn = 1'b1;

    // idle: run ignored without a load
    run = 1'b1; ticks = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (tick) ticks++;
    end
    check("idle_ticks", ticks, 0);
    check("idle_out", {char2, char1, char0, rot_sel, load_ack, running}, 0);

    // load and steady scrolling
    do_load();
    check("ack", load_ack, 1);
    check("chars_load", {char2, char1, char0}, 6'b10_01_00);
    wait_tick(n); check("gap1", n, TD);
    check("chars_t1", {char2, char1, char0}, 6'b00_10_01);
    wait_tick(n); check("gap2", n, TD);
    check("chars_t2", {char2, char1, char0}, 6'b01_00_10);
    wait_tick(n); check("gap3", n, TD);
    check("chars_t3", {char2, char1, char0}, 6'b10_01_00);

    // pause at counter=2
    cycle(); cycle();
    run = 1'b0; ticks = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (tick) ticks++;
    end
    check("pause_ticks", ticks, 0);
    check("pause_rot", rot_sel, 0);
    check("pause_running", running, 0);
    run = 1'b1;
    cycle();
    wait_tick(n); check("resume_gap", n, 2);
    check("resume_rot", rot_sel, 1);

    // load coincident with terminal count
    cycle(); cycle(); cycle();
    do_load();
    check("ld_tc_tick", tick, 0);
    check("ld_tc_rot", rot_sel, 0);
    wait_tick(n); check("ld_tc_gap", n, TD);

    // load held high
    load = 1'b1; ticks = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("hold_ack", load_ack, 1);
      if (tick) ticks++;
    end
    load = 1'b0;
    check("hold_ticks", ticks, 0);

    // run dropped on terminal count
    cycle(); cycle(); cycle();
    run = 1'b0; cycle();
    check("tc_pause_tick", tick, 0);
    run = 1'b1; cycle();
    wait_tick(n); check("tc_resume_gap", n, 1);

    // direction
    dir = 1'b1;
    do_load();
    for (int i = 0; i < 3; i++) begin
      wait_tick(n);
      seq[i] = rot_sel;
    end
`ifdef SCROLL_DIR_EN
    check("dir_seq", {seq[0], seq[1], seq[2]}, 6'b10_01_00);
`else
    check("dir_seq", {seq[0], seq[1], seq[2]}, 6'b01_10_00);
`endif
    dir = 1'b0;

    // reset during RUN at rot_sel=2
    do_load();
    wait_tick(n); wait_tick(n);
    check("pre_rst_rot", rot_sel, 2);
    resetn = 1'b0;
    cycle();
    check("rst_out", {char2, char1, char0, rot_sel, tick, load_ack, running}, 0);
    resetn = 1'b1; ticks = 0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      if (tick) ticks++;
    end
    check("post_rst_ticks", ticks, 0);
    check("post_rst_running", running, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
